// File: rtl/tanh_pwl_stream.sv
// tanh_pwl_stream: two-stage valid/ready approximate tanh.
// Input is Q3.(W-3) signed and output is Q1.(W-1) signed.
// The curve is a five-segment piecewise-linear fit with power-of-two slopes.
// Setting mode=1 on a beat selects hard-tanh for that beat.
// Optional feature macro: TANH_SAT_CNT_EN adds clr_cnt and sat_count.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   In, mode, in_valid   input beat (mode: 0 = PWL, 1 = hard-tanh)
//   in_ready             beat accepted when in_valid & in_ready
//   Out1, out_valid      result beat
//   out_ready            downstream accepts when out_valid & out_ready
//   clr_cnt, sat_count   synchronous clear / saturating count of saturated beats
//                        (TANH_SAT_CNT_EN only)
module tanh_pwl_stream #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     In,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     Out1,
    output logic             out_valid,
    input  logic             out_ready
`ifdef TANH_SAT_CNT_EN
    ,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_count
`endif
);

    localparam int unsigned F      = W - 3;
    localparam int unsigned WX     = W + 2;
    localparam int unsigned R_MAX_I = (1 << (W - 1)) - 1;

    localparam logic [W-1:0]  R_MAX    = W'(R_MAX_I);
    localparam logic [W-1:0]  LIM0     = W'(1 << (F - 1));
    localparam logic [W-1:0]  LIM1     = W'(1 << F);
    localparam logic [W-1:0]  LIM2     = W'(3 << (F - 1));
    localparam logic [W-1:0]  LIM3     = W'(5 << (F - 1));
    localparam logic [W-1:0]  OFF1     = W'(1 << F);
    localparam logic [W-1:0]  OFF2     = W'(1 << (F + 1));
    localparam logic [W-1:0]  BASE3    = W'(7 << (F - 1));
    localparam logic [WX-1:0] HARD_SAT = WX'(R_MAX_I);

    // Reject unsupported widths at elaboration.
    if (W < 6 || CNT_W == 0) begin : g_param_check
        $error("tanh_pwl_stream: W must be >= 6 and CNT_W >= 1");
    end

    // Handshake: stage 2 frees when empty or draining; stage 1 frees when empty or moving on.
    logic s2_load_c;
    logic s1_load_c;
    logic s1_valid;

    always_comb begin
        s2_load_c = !out_valid || out_ready;
        s1_load_c = !s1_valid || s2_load_c;
        in_ready  = s1_load_c;
    end

    // Stage 1 decode: sign, magnitude (|-2^(W-1)| fits as unsigned), segment, saturation.
    logic          s_c;
    logic [W-1:0]  m_c;
    logic [WX-1:0] m4_c;
    logic [2:0]    seg_c;
    logic          sat_c;

    always_comb begin
        s_c  = In[W-1];
        m_c  = s_c ? (W'(0) - In) : In;
        m4_c = {m_c, 2'b00};
        if (m_c < LIM0)      seg_c = 3'd0;
        else if (m_c < LIM1) seg_c = 3'd1;
        else if (m_c < LIM2) seg_c = 3'd2;
        else if (m_c < LIM3) seg_c = 3'd3;
        else                 seg_c = 3'd4;
        sat_c = mode ? (m4_c >= HARD_SAT) : (seg_c == 3'd4);
    end

    logic         s1_s;
    logic [W-1:0] s1_m;
    logic         s1_mode;
    logic [2:0]   s1_seg;
    logic         s1_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_m     <= '0;
            s1_mode  <= 1'b0;
            s1_seg   <= 3'd0;
            s1_sat   <= 1'b0;
        end else if (s1_load_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_s    <= s_c;
                s1_m    <= m_c;
                s1_mode <= mode;
                s1_seg  <= seg_c;
                s1_sat  <= sat_c;
            end
        end
    end

    // Stage 2 evaluate: magnitude in output LSBs, then restore the sign.
    // Where 4m is used, the range guarantees the top two bits of m are zero.
    logic [W-1:0] r_c;
    logic [W-1:0] y_c;

    always_comb begin
        r_c = R_MAX;
        if (s1_mode) begin
            if (!s1_sat) r_c = {s1_m[W-3:0], 2'b00};
        end else begin
            case (s1_seg)
                3'd0:    r_c = {s1_m[W-3:0], 2'b00};
                3'd1:    r_c = {s1_m[W-2:0], 1'b0} + OFF1;
                3'd2:    r_c = s1_m + OFF2;
                3'd3:    r_c = BASE3 + ((s1_m - LIM2) >> 2);
                default: r_c = R_MAX;
            endcase
        end
        y_c = s1_s ? (W'(0) - r_c) : r_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Out1      <= '0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) Out1 <= y_c;
        end
    end

`ifdef TANH_SAT_CNT_EN
    // Saturation flag travels with the beat; counted on output handshake, clear wins.
    logic s2_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sat <= 1'b0;
        end else if (s2_load_c && s1_valid) begin
            s2_sat <= s1_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_cnt) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && s2_sat && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tanh_pwl_stream.sv
// Directed bench for tanh_pwl_stream (W=8, CNT_W=2) with hand-computed results.
module tb_tanh_pwl_stream;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] In;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Out1;
    logic         out_valid;
    logic         out_ready;
`ifdef TANH_SAT_CNT_EN
    logic         clr_cnt;
    logic [1:0]   sat_count;
`endif

    tanh_pwl_stream #(.W(W), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In        (In),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out1      (Out1),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef TANH_SAT_CNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] tx_d[$];
    logic       tx_m[$];
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         acc_cyc[$];
    logic [7:0] exp_q[$];

    logic [7:0] snap_out;
    logic       snap_valid;
    logic       snap_rdy;

    // Record every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_q.push_back(Out1);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic m);
        tx_d.push_back(d);
        tx_m.push_back(m);
    endtask

    task automatic drive_front();
        in_valid = (tx_d.size() > 0);
        if (tx_d.size() > 0) begin
            In   = tx_d[0];
            mode = tx_m[0];
        end
    endtask

    // One clock: present head beat, sample at negedge, retire it if accepted.
    task automatic cycle();
        logic acc;
        drive_front();
        @(negedge clk);
        acc        = in_valid && in_ready;
        snap_out   = Out1;
        snap_valid = out_valid;
        snap_rdy   = in_ready;
        if (acc) acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (acc) begin
            void'(tx_d.pop_front());
            void'(tx_m.pop_front());
        end
        drive_front();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (tx_d.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        repeat (4) cycle();
        check($sformatf("%s_all_accepted", tag), tx_d.size(), 0);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic check_stream(input string tag, input bit lat);
        check($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), rx_q[i], exp_q[i]);
            if (lat && i < acc_cyc.size())
                check($sformatf("%s_lat%0d", tag, i), rx_cyc[i] - acc_cyc[i], 2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        In        = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
`ifdef TANH_SAT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out1", Out1, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef TANH_SAT_CNT_EN
        check("rst_sat_count", sat_count, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // PWL segments back to back
        clear_rx();
        push(8'h08, 0); push(8'h18, 0); push(8'hD8, 0); push(8'h40, 0);
        drain("pwl");
        exp_q = '{8'h20, 8'h50, 8'h98, 8'h74};
        check_stream("pwl", 1);
        if (rx_cyc.size() == 4) check("pwl_consecutive", rx_cyc[3] - rx_cyc[0], 3);

        // PWL saturation including the most negative input
        clear_rx();
        push(8'h60, 0); push(8'h80, 0); push(8'h7F, 0);
        drain("sat");
        exp_q = '{8'h7F, 8'h81, 8'h7F};
        check_stream("sat", 1);
`ifdef TANH_SAT_CNT_EN
        check("sat_count_3", sat_count, 3);
`endif

        // Hard-tanh with an interleaved PWL beat
        clear_rx();
        push(8'h18, 1); push(8'hD8, 1); push(8'h18, 0); push(8'h04, 1);
        drain("hard");
        exp_q = '{8'h60, 8'h81, 8'h50, 8'h10};
        check_stream("hard", 1);

        // Backpressure mid-stream
        clear_rx();
        out_ready = 1'b1;
        push(8'h08, 0); push(8'h18, 0); push(8'hD8, 0);
        push(8'h40, 0); push(8'h04, 0); push(8'h10, 0);
        cycle();
        cycle();
        out_ready = 1'b0;
        cycle();
        check("bp_in_ready_low", snap_rdy, 0);
        check("bp_valid", snap_valid, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("bp_hold%0d", i), snap_out, 8'h20);
            check($sformatf("bp_hold_valid%0d", i), snap_valid, 1);
            check($sformatf("bp_hold_rdy%0d", i), snap_rdy, 0);
        end
        check("bp_no_handshake", rx_q.size(), 0);
        out_ready = 1'b1;
        drain("bp");
        exp_q = '{8'h20, 8'h50, 8'h98, 8'h74, 8'h10, 8'h40};
        check_stream("bp", 0);

        // Reset with both stages full
        clear_rx();
        out_ready = 1'b0;
        push(8'h18, 0); push(8'h40, 0); push(8'h08, 0);
        cycle();
        cycle();
        cycle();
        check("mid_full_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out1", Out1, 0);
        check("mid_rst_in_ready", in_ready, 1);
`ifdef TANH_SAT_CNT_EN
        check("mid_rst_sat_count", sat_count, 0);
`endif
        tx_d.delete();
        tx_m.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_mid_rst_valid", out_valid, 0);
        clear_rx();
        out_ready = 1'b1;
        push(8'h08, 0);
        drain("after_rst");
        exp_q = '{8'h20};
        check_stream("after_rst", 1);

`ifdef TANH_SAT_CNT_EN
        // Counter saturates at 3 for a 2-bit counter
        clear_rx();
        check("cnt_start", sat_count, 0);
        for (int i = 0; i < 5; i++) push(8'h7F, 0);
        drain("cnt5");
        check("cnt5_beats", rx_q.size(), 5);
        check("cnt5_held", sat_count, 3);

        // Clear coincident with a saturating handshake
        clear_rx();
        out_ready = 1'b0;
        push(8'h80, 0);
        for (int i = 0; i < 10 && !out_valid; i++) cycle();
        check("clr_staged", out_valid, 1);
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        check("clr_wins", sat_count, 0);
        check("clr_beat_out", rx_q.size(), 1);
        if (rx_q.size() == 1) check("clr_beat_val", rx_q[0], 8'h81);

        // Hard-mode saturation counts, a non-saturating beat does not
        clear_rx();
        push(8'h60, 1);
        drain("cnt_hard");
        check("cnt_hard_one", sat_count, 1);
        push(8'h08, 0);
        drain("cnt_nosat");
        check("cnt_nosat_one", sat_count, 1);
        exp_q = '{8'h7F, 8'h20};
        check_stream("cnt_tail", 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tanh_pwl_stream.md
# tanh_pwl_stream

Parametrised, pipelined approximate tanh unit for the activation-function library. It succeeds the fixed 4-bit combinational approximations with the following:
- a W-bit signed fixed-point datapath;
- a five-segment piecewise-linear (PWL) curve using power-of-two slopes;
- a per-beat hard-tanh mode;
- a two-stage valid/ready pipeline that sits between a MAC array and the next layer's input buffer.

## Interface
- W, 8, data width; input Q3.(W-3) signed, output Q1.(W-1) signed; W >= 6 (elaboration error otherwise)
- CNT_W, 16, saturation counter width (used only with TANH_SAT_CNT_EN)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- In  in  W  input sample x, two's complement, F = W-3 fractional bits
- mode  in  1  0 = PWL, 1 = hard-tanh; sampled with In
- in_valid  in  1  In/mode valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- Out1  out  W  result y, two's complement, W-1 fractional bits
- out_valid  out  1  Out1 valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- clr_cnt  in  1  synchronous clear of sat_count (macro only)
- sat_count  out  CNT_W  saturating-beat count (macro only)

## Operation
- **Symmetry:** s = In[W-1]; m = |In| as unsigned W bits, so -2^(W-1) yields m = 2^(W-1). The magnitude result r is computed in output LSB units; Out1 = s ? -r : r.
- **PWL segments (mode=0):**
  - m < 2^(F-1): r = 4m
  - m < 2^F: r = 2m + 2^F
  - m < 3·2^(F-1): r = m + 2^(F+1)
  - m < 5·2^(F-1): r = 7·2^(F-1) + ((m - 3·2^(F-1)) >> 2), truncating
  - otherwise (saturation): r = 2^(W-1) - 1
- **Hard-tanh (mode=1):** r = min(4m, 2^(W-1) - 1). Saturation is 4m >= 2^(W-1) - 1.
- Output is symmetric: the most negative output is -(2^(W-1) - 1), never -2^(W-1).
- **Pipeline registers:**
  - Stage 1 (S1): registers s, m, mode, the segment index (0-4), and the saturation flag.
  - Stage 2 (S2): registers Out1 and the sat flag.
  - Each stage has a valid bit. There is no FSM beyond these valid bits.

## Timing
- Latency is 2 cycles: a beat accepted at edge n presents on Out1/out_valid after edge n+2, provided out_ready is held high.
- Throughput is 1 beat/cycle.
- Load enables:
  - S2 loads when !out_valid | out_ready.
  - S1 loads when !s1_valid | s2_load.
  - in_ready = s1_load. This is combinational from out_ready, and bubbles collapse.
- When out_valid & !out_ready, Out1 is held stable until the handshake completes.
- Once in_valid is asserted, In/mode must be held until accepted. The block itself does not depend on this.
- **Reset (rst_n low, at any time, including mid-stream):**
  - All valid bits, Out1, and sat_count are cleared to 0 immediately.
  - Beats in flight are dropped.
  - in_ready reads 1 during and after reset.
- In-flight beats in S1 and S2 are unaffected by a mode change on later beats.

## Configuration
- **TANH_SAT_CNT_EN defined:**
  - Adds clr_cnt and sat_count.
  - sat_count increments by 1 on each output handshake whose beat had the sat flag set.
  - It saturates at 2^CNT_W - 1 and does not wrap.
  - If clr_cnt and an increment occur in the same cycle, the result is 0 (clear wins).
  - Reset value is 0.
- **TANH_SAT_CNT_EN undefined:** both ports are absent, there is no counter logic, and datapath behaviour is identical.

## Test plan
- W=8, mode=0, out_ready=1, back-to-back inputs 0x08, 0x18, 0xD8, 0x40 -> outputs 0x20, 0x50, 0x98, 0x74 on consecutive cycles, each 2 cycles after its input.
- Saturation in mode=0: inputs 0x60, 0x80, 0x7F -> outputs 0x7F, 0x81, 0x7F. With TANH_SAT_CNT_EN, sat_count reaches 3.
- Hard-tanh, mode=1: inputs 0x18, 0xD8, 0x04 -> outputs 0x60, 0x81, 0x10. An interleaved mode=0 beat with 0x18 -> 0x50, unaffected by its neighbours.
- Backpressure: stream 6 beats with out_ready low for 4 cycles mid-stream:
  - in_ready drops once S1 and S2 are full.
  - Out1 stays stable while stalled.
  - No beat is lost or duplicated, and order is preserved.
- Reset mid-stream: assert rst_n low with both stages valid:
  - out_valid goes to 0 without waiting for a clock.
  - After release, the first new beat 0x08 -> 0x20 at latency 2.
- Counter (macro on):
  - With CNT_W=2, 5 saturating beats -> sat_count = 3, held.
  - clr_cnt pulsed together with a saturating handshake -> sat_count = 0.
